// File: rtl/udc_pkg.sv
// udc_pkg: shared definitions for the modulo-N up/down counter.
// Holds the direction encodings and the elaboration-time MODULUS range check.
// Optional saturate mode is controlled by the UDC_SAT_MODE_EN macro.
package udc_pkg;

   localparam logic UDC_DIR_UP   = 1'b1;
   localparam logic UDC_DIR_DOWN = 1'b0;

   // A modulus is legal when it spans at least two states and fits in the counter width.
   function automatic bit udc_modulus_ok(input int width, input int modulus);
      longint span;
      span = longint'(1) << width;
      return (modulus >= 2) && (longint'(modulus) <= span);
   endfunction

endpackage

// File: rtl/udc_next.sv
// udc_next: combinational next-state unit for the modulo-N up/down counter.
// Computes next count and terminal-count flag from the current count and the controls.
// Saturate handling (sat input) exists only when UDC_SAT_MODE_EN is defined.
module udc_next
   import udc_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic [WIDTH-1:0] count,
   input  logic             ud,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SAT_MODE_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] next_count,
   output logic             next_tc
);

   // One extra bit keeps MODULUS = 2^WIDTH from overflowing the bound constant.
   localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

   logic [WIDTH:0] cur_ext;
   logic [WIDTH:0] load_ext;
   logic [WIDTH:0] next_ext;
   logic           sat_mode;
   logic           unused_msb;

   assign cur_ext  = {1'b0, count};
   assign load_ext = {1'b0, load_val};

`ifdef UDC_SAT_MODE_EN
   assign sat_mode = sat;
`else
   assign sat_mode = 1'b0;
`endif

   // Priority load > count > hold; wrap tests compare against MAX_VAL, never rollover.
   always_comb begin
      next_ext = cur_ext;
      next_tc  = 1'b0;
      if (load) begin
         next_ext = (load_ext > MAX_VAL) ? MAX_VAL : load_ext;
      end else if (en) begin
         if (ud == UDC_DIR_UP) begin
            if (cur_ext < MAX_VAL) begin
               next_ext = cur_ext + ONE;
               if (sat_mode && (next_ext == MAX_VAL)) begin
                  next_tc = 1'b1;
               end
            end else if (!sat_mode) begin
               next_ext = '0;
               next_tc  = 1'b1;
            end
         end else begin
            if (cur_ext != '0) begin
               next_ext = cur_ext - ONE;
               if (sat_mode && (cur_ext == ONE)) begin
                  next_tc = 1'b1;
               end
            end else if (!sat_mode) begin
               next_ext = MAX_VAL;
               next_tc  = 1'b1;
            end
         end
      end
   end

   assign next_count = next_ext[WIDTH-1:0];
   assign unused_msb = next_ext[WIDTH];

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised modulo-N up/down counter with load and
// registered terminal-count pulse. Define UDC_SAT_MODE_EN to add the sat port
// and per-cycle saturate-at-bounds behaviour; otherwise the counter always wraps.
module updown_counter_mod
   import udc_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ud,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SAT_MODE_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   logic [WIDTH-1:0] next_count;
   logic             next_tc;

   if (!udc_modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("updown_counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   udc_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count      (count),
      .ud         (ud),
      .en         (en),
      .load       (load),
      .load_val   (load_val),
`ifdef UDC_SAT_MODE_EN
      .sat        (sat),
`endif
      .next_count (next_count),
      .next_tc    (next_tc)
   );

   // State registers; active-low reset clears count and tc without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= next_count;
         tc    <= next_tc;
      end
   end

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: directed bench for updown_counter_mod.
// Two instances share stimulus: MODULUS=10 and MODULUS=16 (full range), WIDTH=4.
// Saturate steps are included only when UDC_SAT_MODE_EN is defined.
module tb_updown_counter_mod;

   logic       clk;
   logic       rst;
   logic       en;
   logic       ud;
   logic       load;
   logic [3:0] load_val;
   logic       sat;
   logic [3:0] count10;
   logic       tc10;
   logic [3:0] count16;
   logic       tc16;

   int n_checks;
   int n_fail;

   updown_counter_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ud       (ud),
      .load     (load),
      .load_val (load_val),
`ifdef UDC_SAT_MODE_EN
      .sat      (sat),
`endif
      .count    (count10),
      .tc       (tc10)
   );

   updown_counter_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ud       (ud),
      .load     (load),
      .load_val (load_val),
`ifdef UDC_SAT_MODE_EN
      .sat      (sat),
`endif
      .count    (count16),
      .tc       (tc16)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic en_i, input logic ud_i, input logic load_i,
                                input logic [3:0] val_i);
      en       = en_i;
      ud       = ud_i;
      load     = load_i;
      load_val = val_i;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [4:0] observed,
                              input logic [4:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   int exp_up [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int exp_tc [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

   // Directed sequence following the test plan, one step per clock.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      sat      = 1'b0;
      rst      = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      #1 rst = 1'b0;
      #2;
      checkOutput("reset_count_async", {1'b0, count10}, 5'd0);
      checkOutput("reset_tc_async", {4'b0, tc10}, 5'd0);
      stepClock();
      stepClock();
      checkOutput("reset_count_held", {1'b0, count10}, 5'd0);

      // Release reset with counting enabled; first edge is a normal count step.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 11; i++) begin
         stepClock();
         checkOutput($sformatf("up_count_%0d", i), {1'b0, count10}, 5'(exp_up[i]));
         checkOutput($sformatf("up_tc_%0d", i), {4'b0, tc10}, 5'(exp_tc[i]));
      end

      // Wrap down: load 1, then three down steps 0, 9, 8.
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd1);
      stepClock();
      checkOutput("dn_load_count", {1'b0, count10}, 5'd1);
      checkOutput("dn_load_tc", {4'b0, tc10}, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      stepClock();
      checkOutput("dn_count_0", {1'b0, count10}, 5'd0);
      checkOutput("dn_tc_0", {4'b0, tc10}, 5'd0);
      stepClock();
      checkOutput("dn_count_9", {1'b0, count10}, 5'd9);
      checkOutput("dn_tc_9", {4'b0, tc10}, 5'd1);
      stepClock();
      checkOutput("dn_count_8", {1'b0, count10}, 5'd8);
      checkOutput("dn_tc_8", {4'b0, tc10}, 5'd0);

      // Load beats enable and clamps above MODULUS-1.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd12);
      stepClock();
      checkOutput("clamp_count10", {1'b0, count10}, 5'd9);
      checkOutput("clamp_tc10", {4'b0, tc10}, 5'd0);
      checkOutput("noclamp_count16", {1'b0, count16}, 5'd12);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd5);
      stepClock();
      checkOutput("load5_count", {1'b0, count10}, 5'd5);

      // Hold with en low, then direction up resumes counting.
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      stepClock();
      checkOutput("hold_count", {1'b0, count10}, 5'd5);
      checkOutput("hold_tc", {4'b0, tc10}, 5'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      stepClock();
      checkOutput("resume_up_count", {1'b0, count10}, 5'd6);

      // Full range: MODULUS=16 must visit 15 before wrapping to 0.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd14);
      stepClock();
      checkOutput("full_load_count16", {1'b0, count16}, 5'd14);
      checkOutput("full_load_count10", {1'b0, count10}, 5'd9);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      stepClock();
      checkOutput("full_count16_15", {1'b0, count16}, 5'd15);
      checkOutput("full_tc16_15", {4'b0, tc16}, 5'd0);
      checkOutput("wrap_count10_0", {1'b0, count10}, 5'd0);
      checkOutput("wrap_tc10_0", {4'b0, tc10}, 5'd1);
      stepClock();
      checkOutput("full_count16_0", {1'b0, count16}, 5'd0);
      checkOutput("full_tc16_0", {4'b0, tc16}, 5'd1);
      checkOutput("after_wrap_tc10", {4'b0, tc10}, 5'd0);

      // Asynchronous reset mid-cycle, with a load pending that must be discarded.
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd7);
      stepClock();
      checkOutput("pre_rst_count", {1'b0, count10}, 5'd7);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd3);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid_rst_count", {1'b0, count10}, 5'd0);
      checkOutput("mid_rst_tc", {4'b0, tc10}, 5'd0);
      stepClock();
      checkOutput("rst_load_discard", {1'b0, count10}, 5'd0);
      #2 rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      stepClock();
      checkOutput("post_rst_count_1", {1'b0, count10}, 5'd1);
      stepClock();
      checkOutput("post_rst_count_2", {1'b0, count10}, 5'd2);

`ifdef UDC_SAT_MODE_EN
      // Saturate up from 8: 9 with one tc, then stuck at 9.
      sat = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd8);
      stepClock();
      checkOutput("sat_load8", {1'b0, count10}, 5'd8);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         stepClock();
         checkOutput($sformatf("sat_up_count_%0d", i), {1'b0, count10}, 5'd9);
         checkOutput($sformatf("sat_up_tc_%0d", i), {4'b0, tc10}, (i == 0) ? 5'd1 : 5'd0);
      end
      // Saturate down from 1: 0 with one tc, then stuck at 0.
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd1);
      stepClock();
      checkOutput("sat_load1", {1'b0, count10}, 5'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         stepClock();
         checkOutput($sformatf("sat_dn_count_%0d", i), {1'b0, count10}, 5'd0);
         checkOutput($sformatf("sat_dn_tc_%0d", i), {4'b0, tc10}, (i == 0) ? 5'd1 : 5'd0);
      end
      sat = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
